// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative radix-2 multiply/divide unit holding the HI/LO pair.
// Executes DMULTU/DMULT/DDIVU/DDIV over WIDTH cycles plus one fixup cycle.
// Define MULDIV_DIV_EN to build the divide datapath; without it, divide
// requests are ignored and o_div_zero is tied low.
module muldiv_hilo #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_hi_write,
  input  logic             i_lo_write,
  input  logic [WIDTH-1:0] i_write_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e r_state, w_state_next;

  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic               r_sign_a, r_sign_b, r_done;

  logic               w_accept, w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_res_hi, w_res_lo;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_prod, w_step;

  // Operand magnitude and sign capture; only signed ops (op[0]) see a sign.
  assign w_neg_a = i_op[0] & i_src_a[WIDTH-1];
  assign w_neg_b = i_op[0] & i_src_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -i_src_a : i_src_a;
  assign w_mag_b = w_neg_b ? -i_src_b : i_src_b;

  // Multiply step: add multiplicand into the upper half, shift right keeping the carry.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      {1'b0, (r_b[0] ? r_a : {WIDTH{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
  logic               r_div, r_div_zero, w_div_zero;
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic [WIDTH-1:0]   w_quot, w_rem, w_orig_a;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_accept = i_start & (r_state == StIdle);

  // Restoring divide step on {remainder, quotient}; the shifted remainder needs WIDTH+1 bits.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_step     = r_div ? w_div_next : w_mul_next;

  // Quotient negated on differing signs; remainder follows the dividend sign.
  assign w_quot     = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem      = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  // Rebuild srcA as supplied; -(most-negative) maps back onto itself.
  assign w_orig_a   = r_sign_a ? -r_a : r_a;
  assign w_div_zero = r_div & (r_b == '0);

  // Select the architectural HI/LO result written in FIX.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      w_res_hi = w_div_zero ? w_orig_a : w_rem;
      w_res_lo = w_div_zero ? {WIDTH{1'b1}} : w_quot;
    end
  end

  assign o_div_zero = r_div_zero;
`else
  // Divide requests are dropped entirely in this build.
  assign w_accept = i_start & ~i_op[1] & (r_state == StIdle);
  assign w_step   = w_mul_next;

  // Select the architectural HI/LO result written in FIX.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
  end

  assign o_div_zero = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  // Next-state: RUN lasts exactly WIDTH cycles, FIX one.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (r_cnt == CntW'(1)) w_state_next = StFix;
      StFix:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath, HI/LO and completion flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_done     <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_div      <= 1'b0;
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_div_zero <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          // MT writes land now; a same-cycle start overwrites them later in FIX.
          if (i_hi_write) r_hi <= i_write_data;
          if (i_lo_write) r_lo <= i_write_data;
          if (w_accept) begin
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            r_a      <= w_mag_a;
            r_b      <= w_mag_b;
            r_cnt    <= CntW'(WIDTH);
`ifdef MULDIV_DIV_EN
            r_div    <= i_op[1];
            // Dividend sits in the quotient half and shifts out as quotient bits shift in.
            r_acc    <= i_op[1] ? {{WIDTH{1'b0}}, w_mag_a} : '0;
`else
            r_acc    <= '0;
`endif
          end
        end
        StRun: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CntW'(1);
`ifdef MULDIV_DIV_EN
          if (!r_div) r_b <= r_b >> 1;
`else
          r_b <= r_b >> 1;
`endif
        end
        StFix: begin
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_done <= 1'b1;
`ifdef MULDIV_DIV_EN
          r_div_zero <= w_div_zero;
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != StIdle);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed self-checking bench for muldiv_hilo (WIDTH=64).
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [63:0] src_a = '0, src_b = '0, write_data = '0;
  logic        hi_write = 1'b0, lo_write = 1'b0;
  logic        busy, done, div_zero;
  logic [63:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

  muldiv_hilo #(.WIDTH(64)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_op         (op),
    .i_src_a      (src_a),
    .i_src_b      (src_b),
    .i_hi_write   (hi_write),
    .i_lo_write   (lo_write),
    .i_write_data (write_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_div_zero   (div_zero),
    .o_hi         (hi),
    .o_lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: present start for one edge, return at the next negedge.
  task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_a = 64'hDEAD_BEEF_0BAD_F00D; // operands must already be captured
    src_b = 64'h1234_5678_9ABC_DEF0;
  endtask

  // Count edges after the start edge until done; ends at the negedge where done=1.
  task automatic wait_done(input string tag, input logic [63:0] exp_hi,
                           input logic [63:0] exp_lo, input logic exp_dz);
    int cyc = 0;
    check_eq({tag, " busy"}, 64'(busy), 64'd1);
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, " latency"}, 64'(cyc), 64'd65);
    check_eq({tag, " busy@done"}, 64'(busy), 64'd0);
    check_eq({tag, " hi"}, hi, exp_hi);
    check_eq({tag, " lo"}, lo, exp_lo);
    check_eq({tag, " divzero"}, 64'(div_zero), 64'(exp_dz));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_hi,
                        input logic [63:0] exp_lo, input logic exp_dz);
    @(negedge clk);
    issue(o, a, b);
    wait_done(tag, exp_hi, exp_lo, exp_dz);
    @(negedge clk);
    check_eq({tag, " done pulse"}, 64'(done), 64'd0);
    check_eq({tag, " divzero clr"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    int pulses;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst done", 64'(done), 64'd0);
    check_eq("rst divzero", 64'(div_zero), 64'd0);
    check_eq("rst hi", hi, 64'd0);
    check_eq("rst lo", lo, 64'd0);

    run_op("dmultu max*2", 2'b00, Ones, 64'd2, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("dmult -3*5", 2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, Ones,
           64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_op("dmult -1*-1", 2'b01, Ones, Ones, 64'h0, 64'h1, 1'b0);
    run_op("dmultu max*max", 2'b00, Ones, Ones, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1'b0);

`ifdef MULDIV_DIV_EN
    run_op("ddiv -7/2", 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, Ones,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("ddiv minneg/-1", 2'b11, 64'h8000_0000_0000_0000, Ones, 64'h0,
           64'h8000_0000_0000_0000, 1'b0);
    run_op("ddiv 7/-2", 2'b11, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("ddivu 100/7", 2'b10, 64'd100, 64'd7, 64'd2, 64'd14, 1'b0);
    run_op("ddivu 100/0", 2'b10, 64'd100, 64'd0, 64'h64, Ones, 1'b1);
    run_op("ddiv -5/0", 2'b11, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB,
           Ones, 1'b1);
`else
    // Divide requests are dropped: no busy, no done, HI/LO untouched.
    @(negedge clk);
    issue(2'b10, 64'd100, 64'd7);
    check_eq("nodiv busy", 64'(busy), 64'd0);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check_eq("nodiv activity", 64'(pulses), 64'd0);
    check_eq("nodiv hi", hi, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("nodiv lo", lo, 64'h1);
`endif

    // MT write and second start during busy are both dropped.
    @(negedge clk);
    issue(2'b00, 64'd3, 64'd4);
    repeat (4) @(negedge clk);
    hi_write = 1'b1; write_data = 64'hAA;
    @(negedge clk);
    hi_write = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 64'd7; src_b = 64'd7;
    @(negedge clk);
    start = 1'b0;
    // Rejoin wait_done's counting at the proper offset (10 edges already elapsed).
    begin
      int cyc = 10;
      while (!done && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check_eq("busy-ignore latency", 64'(cyc), 64'd65);
      check_eq("busy-ignore hi", hi, 64'h0);
      check_eq("busy-ignore lo", lo, 64'd12);
    end
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("no queued start", 64'(pulses), 64'd0);

    hi_write = 1'b1; write_data = 64'hAA;
    @(negedge clk);
    hi_write = 1'b0;
    check_eq("mthi idle hi", hi, 64'hAA);
    check_eq("mthi idle lo", lo, 64'd12);

    // MTLO together with start: write lands first, result overwrites later.
    lo_write = 1'b1; write_data = 64'h55;
    issue(2'b00, 64'd2, 64'd3);
    lo_write = 1'b0;
    check_eq("mtlo+start lo", lo, 64'h55);
    wait_done("mtlo+start", 64'h0, 64'd6, 1'b0);
    // Back-to-back: start in the done cycle is accepted.
    issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_done("b2b dmult", 64'h0, 64'd4, 1'b0);

    // Reset mid-operation: clears HI/LO, no done pulse afterwards.
    @(negedge clk);
    hi_write = 1'b1; lo_write = 1'b1; write_data = 64'h77;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
`ifdef MULDIV_DIV_EN
    issue(2'b10, 64'd1000, 64'd3);
`else
    issue(2'b00, 64'd1000, 64'd3);
`endif
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst busy", 64'(busy), 64'd0);
    check_eq("midrst hi", hi, 64'h0);
    check_eq("midrst lo", lo, 64'h0);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("midrst no done", 64'(pulses), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

- Iterative 64-bit multiply/divide unit for the MIPS64 datapath.
- Sits directly downstream of the register file: it takes the rs/rt read data and executes DMULT, DMULTU, DDIV and DDIVU.
- Holds the architectural HI/LO pair, which is also written by MTHI/MTLO and read by MFHI/MFLO.
- Uses a radix-2 shift-add / restoring-subtract datapath over WIDTH cycles, with a start/busy/done handshake to the control unit.

## Interface
- WIDTH, 64, operand and HI/LO width; must be even and at least 4.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  00 DMULTU, 01 DMULT, 10 DDIVU, 11 DDIV.
- srcA  in  WIDTH  rs operand (multiplicand / dividend).
- srcB  in  WIDTH  rt operand (multiplier / divisor).
- hiWrite  in  1  MTHI strobe.
- loWrite  in  1  MTLO strobe.
- writeData  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- divZero  out  1  valid only with done; high when the divisor was 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Latch op and the operand magnitudes (absolute values for signed ops, raw values for unsigned).
  - Latch the sign of each operand.
  - Clear the accumulator, load the step counter with WIDTH, go to RUN.
- RUN, multiply:
  - Each cycle, if multiplier bit 0 is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator.
  - Then shift the accumulator right by 1, keeping the carry.
- RUN, divide:
  - Each cycle, shift {remainder, quotient} left by 1.
  - If remainder >= divisor, subtract the divisor and set quotient bit 0.
- The counter decrements every RUN cycle; on reaching 0, go to FIX.
- FIX: apply signs, write hi/lo, pulse done, return to IDLE.
  - DMULT: negate the full 2*WIDTH product when the operand signs differ. hi = upper half, lo = lower half.
  - DDIV: negate the quotient when the signs differ; the remainder takes the sign of the dividend. lo = quotient, hi = remainder.
  - Unsigned ops: no sign fixup.
- Divide by zero:
  - lo = all ones, hi = srcA as originally supplied (signed or not).
  - divZero=1 with done.
  - The full-length run still executes; latency does not change.
- Overflow, most-negative / -1: lo = most-negative value (wraps), hi = 0. No flag.
- hiWrite/loWrite:
  - Take effect only in IDLE, on the next edge.
  - Ignored while busy; the in-flight result wins.
  - If start and hiWrite/loWrite arrive in the same IDLE cycle, both are accepted: the MT write lands first and the result later overwrites it.
- start while busy is ignored and is not queued.
- Operands are captured at start; srcA and srcB may change afterwards.

## Timing
- Reset values: state IDLE, busy=0, done=0, divZero=0, hi=0, lo=0.
- Reset mid-operation: back to IDLE on that edge, with no done pulse and hi/lo cleared.
- busy rises on the edge that samples start and stays high through FIX.
- hi, lo, done and divZero all update on the edge WIDTH+1 edges after the start edge. That is 65 cycles for WIDTH=64.
- done is high for exactly one cycle, and busy is 0 in that same cycle.
- Back-to-back: start may be asserted in the cycle where done=1. That cycle is IDLE, so the start is accepted.
- divZero returns to 0 on the cycle after done.
- MFHI/MFLO consumers read hi and lo directly. The values are stable except on the FIX edge or an MT write edge.

## Configuration
- MULDIV_DIV_EN defined: full behaviour as specified above.
- MULDIV_DIV_EN undefined:
  - The divide datapath and comparator are compiled out.
  - start with op[1]=1 is ignored: busy stays 0, no done pulse, hi/lo unchanged.
  - divZero is tied to 0.
  - Multiply behaviour and latency are unchanged.

## Test plan
- DMULTU with srcA=0xFFFF_FFFF_FFFF_FFFF, srcB=2 -> done at start+65 edges, hi=0x1, lo=0xFFFF_FFFF_FFFF_FFFE, divZero=0.
- DMULT with srcA=-3, srcB=5 -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFF1.
- DDIV with srcA=-7, srcB=2 -> lo=0xFFFF_FFFF_FFFF_FFFD (-3), hi=0xFFFF_FFFF_FFFF_FFFF (-1); then DDIV with srcA=0x8000_0000_0000_0000, srcB=-1 -> lo=0x8000_0000_0000_0000, hi=0.
- DDIVU with srcA=100, srcB=0 -> lo=all ones, hi=0x64, divZero=1 for one cycle together with done.
- DMULTU 3*4 started; hiWrite with writeData=0xAA at busy cycle 5; a second start at cycle 10 -> both ignored; hi=0, lo=12. Then hiWrite with writeData=0xAA in IDLE -> hi=0xAA next cycle.
- DDIVU started, reset asserted for 1 cycle at cycle 20 -> busy=0, hi=lo=0, and no done pulse in the following 70 cycles.
